jnt_cmd_seq: RTL and testbench

JNT_CMD_SEQ -- requirements
Module: jnt_cmd_seq

---
 rtl/jnt_cmd_seq_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/jnt_cmd_seq.sv | 131 +++++++++++++
 tb/tb_jnt_cmd_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jnt_cmd_seq_pkg.sv
// Shared constants and FSM encoding for the joint-command sequencer.
package jnt_cmd_seq_pkg;

    localparam int FIFO_DEPTH_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int CMD_W              = 96;

    // 32-bit truncations of the forward-kinematics initial constants
    localparam logic [31:0] INIT_A1  = 32'd0;
    localparam logic [31:0] INIT_A3  = 32'd112855247;
    localparam logic [31:0] INIT_A4  = 32'd3582936969;
    localparam logic [31:0] INIT_NA1 = 32'd3190547134;
    localparam logic [31:0] INIT_NA3 = 32'd3303402381;
    localparam logic [31:0] INIT_NA4 = 32'd2478516807;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; push/pop are qualified by the caller.
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/jnt_cmd_seq.sv
// Joint-delta command sequencer: queues deltas, accumulates angles, hands
// each angle set to the FK stage and waits (with timeout) for completion.
module jnt_cmd_seq
    import jnt_cmd_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_jnt0,
    input  logic [31:0] cmd_jnt1,
    input  logic [31:0] cmd_jnt2,
    input  logic        home,
    output logic        fk_valid,
    input  logic        fk_ready,
    input  logic        fk_done,
    output logic [31:0] fk_a1,
    output logic [31:0] fk_a3,
    output logic [31:0] fk_a4,
    output logic [31:0] fk_na1,
    output logic [31:0] fk_na3,
    output logic [31:0] fk_na4,
    output logic        busy,
    output logic        err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state;
    logic [31:0]        a1, a3, a4, na1, na3, na4;
    logic [31:0]        d0, d1, d2;
    logic               home_pend;
    logic [TW-1:0]      tcnt;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CMD_W-1:0]   fifo_rdata;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    // A pending home always wins over a pop in the same IDLE cycle.
    assign fifo_pop  = (state == S_IDLE) && !home_pend && !fifo_empty;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({cmd_jnt2, cmd_jnt1, cmd_jnt0}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fk_valid    <= 1'b0;
            err_timeout <= 1'b0;
            home_pend   <= 1'b0;
            tcnt        <= '0;
            d0          <= '0;
            d1          <= '0;
            d2          <= '0;
            a1          <= INIT_A1;
            a3          <= INIT_A3;
            a4          <= INIT_A4;
            na1         <= INIT_NA1;
            na3         <= INIT_NA3;
            na4         <= INIT_NA4;
        end else begin
            if (home) begin
                home_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (home_pend) begin
                        a1        <= INIT_A1;
                        a3        <= INIT_A3;
                        a4        <= INIT_A4;
                        na1       <= INIT_NA1;
                        na3       <= INIT_NA3;
                        na4       <= INIT_NA4;
                        home_pend <= home;
                    end else if (!fifo_empty) begin
                        {d2, d1, d0} <= fifo_rdata;
                        state        <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    a1       <= a1 + d0;
                    a3       <= a3 + d1;
                    a4       <= a4 - d2 - d1;
                    na1      <= na1 + d0;
                    na3      <= na3 + d1;
                    na4      <= na4 - d2 - d1;
                    fk_valid <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (fk_ready) begin
                        fk_valid <= 1'b0;
                        tcnt     <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fk_done) begin
                        state <= S_IDLE;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign fk_a1  = a1;
    assign fk_a3  = a3;
    assign fk_a4  = a4;
    assign fk_na1 = na1;
    assign fk_na3 = na3;
    assign fk_na4 = na4;
    assign busy   = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jnt_cmd_seq.sv
// Directed + randomized bench; expected angles come from a queue of accepted
// commands applied in order to a six-angle model.
module tb_jnt_cmd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_jnt0 = '0, cmd_jnt1 = '0, cmd_jnt2 = '0;
    logic        home = 1'b0;
    logic        fk_valid;
    logic        fk_ready = 1'b0;
    logic        fk_done = 1'b0;
    logic [31:0] fk_a1, fk_a3, fk_a4, fk_na1, fk_na3, fk_na4;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] j0;
        logic [31:0] j1;
        logic [31:0] j2;
    } cmd_t;

    cmd_t        q[$];
    logic [31:0] m[6];

    jnt_cmd_seq dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_jnt0    (cmd_jnt0),
        .cmd_jnt1    (cmd_jnt1),
        .cmd_jnt2    (cmd_jnt2),
        .home        (home),
        .fk_valid    (fk_valid),
        .fk_ready    (fk_ready),
        .fk_done     (fk_done),
        .fk_a1       (fk_a1),
        .fk_a3       (fk_a3),
        .fk_a4       (fk_a4),
        .fk_na1      (fk_na1),
        .fk_na3      (fk_na3),
        .fk_na4      (fk_na4),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic init_model();
        m[0] = 32'd0;
        m[1] = 32'd112855247;
        m[2] = 32'd3582936969;
        m[3] = 32'd3190547134;
        m[4] = 32'd3303402381;
        m[5] = 32'd2478516807;
    endtask

    task automatic apply(input cmd_t c);
        m[0] = m[0] + c.j0;
        m[1] = m[1] + c.j1;
        m[2] = m[2] - c.j2 - c.j1;
        m[3] = m[3] + c.j0;
        m[4] = m[4] + c.j1;
        m[5] = m[5] - c.j2 - c.j1;
    endtask

    task automatic chk_angles(input string tag);
        chk({tag, "/a1"},  fk_a1,  m[0]);
        chk({tag, "/a3"},  fk_a3,  m[1]);
        chk({tag, "/a4"},  fk_a4,  m[2]);
        chk({tag, "/na1"}, fk_na1, m[3]);
        chk({tag, "/na3"}, fk_na3, m[4]);
        chk({tag, "/na4"}, fk_na4, m[5]);
    endtask

    // One clock; an offered command that meets cmd_ready at the edge is recorded.
    task automatic tick();
        logic acc;
        cmd_t c;
        acc = cmd_valid && cmd_ready && !reset;
        @(posedge clk);
        #1;
        if (acc) begin
            c.j0 = cmd_jnt0;
            c.j1 = cmd_jnt1;
            c.j2 = cmd_jnt2;
            q.push_back(c);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic push(input logic [31:0] j0, input logic [31:0] j1, input logic [31:0] j2);
        int n;
        n = 0;
        cmd_jnt0 = j0;
        cmd_jnt1 = j1;
        cmd_jnt2 = j2;
        cmd_valid = 1'b1;
        while (cmd_valid && n < 50) begin
            tick();
            n++;
        end
        if (cmd_valid) begin
            chk("push_accept", cmd_valid, 1'b0);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!fk_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "/fk_valid"}, fk_valid, 1'b1);
    endtask

    task automatic issue_check(input string tag);
        cmd_t c;
        wait_valid(tag);
        if (q.size() == 0) begin
            chk({tag, "/queue"}, 32'(q.size()), 32'd1);
        end else begin
            c = q.pop_front();
            apply(c);
            chk_angles(tag);
        end
    endtask

    task automatic finish_cmd();
        fk_ready = 1'b1;
        tick();
        fk_ready = 1'b0;
        chk("handshake_drop", fk_valid, 1'b0);
        fk_done = 1'b1;
        tick();
        fk_done = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        init_model();
    endtask

    task automatic home_idle();
        home = 1'b1;
        tick();
        home = 1'b0;
        tick();
        init_model();
        chk_angles("home_idle");
    endtask

    initial begin
        int stall;
        init_model();

        // reset state
        do_reset();
        chk("rst/fk_valid", fk_valid, 1'b0);
        chk("rst/err", err_timeout, 1'b0);
        chk("rst/cmd_ready", cmd_ready, 1'b1);
        chk("rst/busy", busy, 1'b0);
        chk_angles("rst");

        // first command: two-clock latency and literal results
        fk_ready = 1'b1;
        push(32'd0, 32'd1, 32'd0);
        fk_ready = 1'b0;
        chk("lat/+0", fk_valid, 1'b0);
        tick();
        chk("lat/+1", fk_valid, 1'b0);
        tick();
        chk("lat/+2", fk_valid, 1'b1);
        chk("lit/a3", fk_a3, 32'd112855248);
        chk("lit/a4", fk_a4, 32'd3582936968);
        chk("lit/na3", fk_na3, 32'd3303402382);
        chk("lit/na4", fk_na4, 32'd2478516806);
        issue_check("first");
        finish_cmd();

        // wrap-around of a1
        do_reset();
        push(32'hFFFF_FFFF, 32'd0, 32'd0);
        issue_check("wrap1");
        chk("wrap1/lit", fk_a1, 32'hFFFF_FFFF);
        finish_cmd();
        push(32'd1, 32'd0, 32'd0);
        issue_check("wrap2");
        chk("wrap2/lit", fk_a1, 32'd0);
        finish_cmd();

        // randomized commands with random FK back-pressure and home requests
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                home_idle();
            end else begin
                push($urandom, $urandom, $urandom);
                issue_check("rand");
                stall = $urandom_range(0, 3);
                repeat (stall) tick();
                chk("rand/hold", fk_valid, 1'b1);
                finish_cmd();
            end
        end
        chk("rand/idle", busy, 1'b0);

        // FIFO fills behind a stalled issue, then drains in order
        push($urandom, $urandom, $urandom);
        issue_check("stall/c0");
        for (int k = 0; k < 4; k++) push($urandom, $urandom, $urandom);
        chk("stall/full", cmd_ready, 1'b0);
        cmd_jnt0 = $urandom;
        cmd_jnt1 = $urandom;
        cmd_jnt2 = $urandom;
        cmd_valid = 1'b1;
        repeat (3) tick();
        chk("stall/held_off", cmd_valid, 1'b1);
        chk("stall/fk_valid", fk_valid, 1'b1);
        chk_angles("stall/stable");
        finish_cmd();
        for (int k = 0; k < 5; k++) begin
            issue_check("drain");
            finish_cmd();
        end
        chk("drain/idle", busy, 1'b0);
        chk("drain/cmd_valid", cmd_valid, 1'b0);

        // missing fk_done: timeout after 1024 WAIT cycles, then next command
        push($urandom, $urandom, $urandom);
        issue_check("to/c0");
        fk_ready = 1'b1;
        tick();
        fk_ready = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            if (i == 1) begin
                cmd_jnt0 = $urandom;
                cmd_jnt1 = $urandom;
                cmd_jnt2 = $urandom;
                cmd_valid = 1'b1;
            end
            tick();
        end
        chk("to/before", err_timeout, 1'b0);
        chk("to/busy", busy, 1'b1);
        tick();
        chk("to/after", err_timeout, 1'b1);
        issue_check("to/next");
        finish_cmd();
        chk("to/sticky", err_timeout, 1'b1);

        // home during WAIT with a queued command
        push($urandom, $urandom, $urandom);
        issue_check("hw/c0");
        fk_ready = 1'b1;
        tick();
        fk_ready = 1'b0;
        push($urandom, $urandom, $urandom);
        home = 1'b1;
        tick();
        home = 1'b0;
        init_model();
        fk_done = 1'b1;
        tick();
        fk_done = 1'b0;
        tick();
        chk_angles("hw/restore");
        issue_check("hw/c1");
        finish_cmd();

        // reset in ISSUE with a queued command
        push($urandom, $urandom, $urandom);
        push($urandom, $urandom, $urandom);
        wait_valid("ri");
        reset = 1'b1;
        tick();
        q.delete();
        init_model();
        chk("ri/fk_valid", fk_valid, 1'b0);
        chk("ri/cmd_ready", cmd_ready, 1'b1);
        chk("ri/busy", busy, 1'b0);
        chk_angles("ri");
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
